tcb_peri_gpio_ext: RTL and testbench

//  Extended TCB GPIO controller: per-pin output/input enables, atomic set/clear/toggle of

---
 rtl/tcb_peri_gpio_ext.sv | 237 +++++++++++++++++++++++
 tb/tb_tcb_peri_gpio_ext.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tcb_peri_gpio_ext.sv
// Extended TCB GPIO controller.
// Per-pin output/input enables, atomic set/clear/toggle of output data and per-pin
// interrupts (level, rising, falling, both edges) with sticky W1C status for edge pins.
// Optional input debounce filter enabled by macro TCB_PERI_GPIO_DEBOUNCE_EN.
module tcb_peri_gpio_ext #(
    parameter int unsigned    GDW     = 32,
    parameter int unsigned    CDC     = 2,
    parameter int unsigned    SYS_DAT = 32,
    parameter logic [GDW-1:0] SYS_IRQ = '1,
    parameter int unsigned    DBN     = 4,
    parameter int unsigned    PRW     = 16,
    localparam int unsigned   SYS_ADR = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [GDW-1:0]     gpio_o,
    output logic [GDW-1:0]     gpio_e,
    input  logic [GDW-1:0]     gpio_i,
    input  logic               sys_wen,
    input  logic [SYS_ADR-1:0] sys_wad,
    input  logic [SYS_DAT-1:0] sys_wdt,
    input  logic               sys_ren,
    input  logic [SYS_ADR-1:0] sys_rad,
    output logic [SYS_DAT-1:0] sys_rdt,
    output logic               irq
);

    // Elaboration-time parameter checks
    if (GDW > SYS_DAT) begin : g_err_gdw
        $error("GDW must not exceed SYS_DAT");
    end
    if (CDC == 1) begin : g_err_cdc
        $error("CDC=1 is not a valid synchronizer depth");
    end
    if (CDC == 0) begin : g_warn_cdc
        $warning("CDC=0: input synchronizer bypassed");
    end
    if (DBN < 1 || DBN > 15) begin : g_err_dbn
        $error("DBN must be within 1..15");
    end
    if (PRW == 0 || PRW > SYS_DAT) begin : g_err_prw
        $error("PRW must be within 1..SYS_DAT");
    end

    logic [GDW-1:0] wdt;
    logic [GDW-1:0] syn;
    logic [GDW-1:0] filt;
    logic [GDW-1:0] prv_q;
    logic [GDW-1:0] oe_q, oe_d, od_q, od_d, ie_q, ie_d;
    logic [GDW-1:0] ena_q, ena_d, edg_q, edg_d, pol_q, pol_d, bth_q, bth_d;
    logic [GDW-1:0] sts_q, sts_d, sts_clr, sts, evt;
    logic           unused_sig;

    assign wdt = sys_wdt[GDW-1:0];
    // Reads are side-effect free, and write bits at or above GDW are dropped
    assign unused_sig = sys_ren ^ (^sys_wdt);

    // Input synchronizer
    if (CDC == 0) begin : g_cdc_byp
        assign syn = gpio_i;
    end else begin : g_cdc
        logic [GDW-1:0] cdc_q [CDC];
        // Shift pin inputs through a CDC-deep flop chain
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cdc_q <= '{default: '0};
            end else begin
                cdc_q[0] <= gpio_i;
                for (int i = 1; i < CDC; i++) begin
                    cdc_q[i] <= cdc_q[i-1];
                end
            end
        end
        assign syn = cdc_q[CDC-1];
    end

`ifdef TCB_PERI_GPIO_DEBOUNCE_EN
    logic [PRW-1:0]       pre_q, pre_d, dbc_pre_q, dbc_pre_d;
    logic [GDW-1:0]       dbc_ena_q, dbc_ena_d, filt_q, filt_d;
    logic [GDW-1:0][3:0]  cnt_q, cnt_d;
    logic                 tick;
    logic                 pre_wr;

    assign pre_wr = sys_wen && (sys_wad == 4'd12);
    assign tick   = (pre_q == dbc_pre_q);

    // Prescaler, debounce config and per-pin stability counters
    always_comb begin
        dbc_pre_d = dbc_pre_q;
        dbc_ena_d = dbc_ena_q;
        filt_d    = filt_q;
        cnt_d     = cnt_q;
        if (pre_wr) begin
            dbc_pre_d = sys_wdt[PRW-1:0];
        end
        if (sys_wen && (sys_wad == 4'd13)) begin
            dbc_ena_d = wdt;
        end
        if (pre_wr || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
        for (int i = 0; i < GDW; i++) begin
            if (!dbc_ena_q[i]) begin
                // Track the pin so enabling the filter causes no spurious change
                filt_d[i] = syn[i];
                cnt_d[i]  = '0;
            end else if (syn[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == 4'(DBN - 1)) begin
                    filt_d[i] = syn[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
            if (dbc_ena_d[i] != dbc_ena_q[i]) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            dbc_pre_q <= '0;
            dbc_ena_q <= '0;
            filt_q    <= '0;
            cnt_q     <= '0;
        end else begin
            pre_q     <= pre_d;
            dbc_pre_q <= dbc_pre_d;
            dbc_ena_q <= dbc_ena_d;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign filt = (dbc_ena_q & filt_q) | (~dbc_ena_q & syn);
`else
    assign filt = syn;
`endif

    // Register write decode
    always_comb begin
        oe_d  = oe_q;
        od_d  = od_q;
        ie_d  = ie_q;
        ena_d = ena_q;
        edg_d = edg_q;
        pol_d = pol_q;
        bth_d = bth_q;
        if (sys_wen) begin
            case (sys_wad)
                4'd0:    oe_d  = wdt;
                4'd1:    od_d  = wdt;
                4'd2:    od_d  = od_q | wdt;
                4'd3:    od_d  = od_q & ~wdt;
                4'd4:    od_d  = od_q ^ wdt;
                4'd5:    ie_d  = wdt;
                4'd7:    ena_d = wdt;
                4'd8:    edg_d = wdt;
                4'd9:    pol_d = wdt;
                4'd10:   bth_d = wdt;
                default: ;
            endcase
        end
    end

    // Edge detection and sticky status; a new edge beats a same-cycle clear
    always_comb begin
        evt     = edg_q & ena_q & ((bth_q & (filt ^ prv_q)) |
                                   (~bth_q & pol_q & filt & ~prv_q) |
                                   (~bth_q & ~pol_q & ~filt & prv_q));
        sts_clr = (sys_wen && (sys_wad == 4'd11)) ? wdt : '0;
        sts_d   = ((sts_q & ~sts_clr) | evt) & ena_d & edg_d;
        // Level pins report live state; edge pins report the sticky bit
        sts     = (edg_q & sts_q) | (~edg_q & ena_q & ~(filt ^ pol_q));
    end

    // Control/status registers and previous filtered input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_q  <= '0;
            od_q  <= '0;
            ie_q  <= '0;
            ena_q <= '0;
            edg_q <= '0;
            pol_q <= '0;
            bth_q <= '0;
            sts_q <= '0;
            prv_q <= '0;
        end else begin
            oe_q  <= oe_d;
            od_q  <= od_d;
            ie_q  <= ie_d;
            ena_q <= ena_d;
            edg_q <= edg_d;
            pol_q <= pol_d;
            bth_q <= bth_d;
            sts_q <= sts_d;
            prv_q <= filt;
        end
    end

    // Combinational read mux, zero-extended to the bus width
    always_comb begin
        sys_rdt = '0;
        case (sys_rad)
            4'd0:    sys_rdt = SYS_DAT'(oe_q);
            4'd1,
            4'd2,
            4'd3,
            4'd4:    sys_rdt = SYS_DAT'(od_q);
            4'd5:    sys_rdt = SYS_DAT'(ie_q);
            4'd6:    sys_rdt = SYS_DAT'(ie_q & filt);
            4'd7:    sys_rdt = SYS_DAT'(ena_q);
            4'd8:    sys_rdt = SYS_DAT'(edg_q);
            4'd9:    sys_rdt = SYS_DAT'(pol_q);
            4'd10:   sys_rdt = SYS_DAT'(bth_q);
            4'd11:   sys_rdt = SYS_DAT'(sts);
`ifdef TCB_PERI_GPIO_DEBOUNCE_EN
            4'd12:   sys_rdt = SYS_DAT'(dbc_pre_q);
            4'd13:   sys_rdt = SYS_DAT'(dbc_ena_q);
`endif
            default: sys_rdt = '0;
        endcase
    end

    assign gpio_o = od_q;
    assign gpio_e = oe_q;
    assign irq    = |(sts & SYS_IRQ);

endmodule

// File: tb/tb_tcb_peri_gpio_ext.sv
// Directed self-checking bench for tcb_peri_gpio_ext (GDW=16, CDC=2, SYS_DAT=32).
module tb_tcb_peri_gpio_ext;

    localparam int unsigned GDW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [GDW-1:0]    gpio_o, gpio_e, gpio_i;
    logic              sys_wen, sys_ren, irq;
    logic [3:0]        sys_wad, sys_rad;
    logic [31:0]       sys_wdt, sys_rdt;
    logic [31:0]       rdat;

    int n_total = 0;
    int n_bad   = 0;

    tcb_peri_gpio_ext #(
        .GDW     (GDW),
        .CDC     (2),
        .SYS_DAT (32),
        .DBN     (4),
        .PRW     (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gpio_o  (gpio_o),
        .gpio_e  (gpio_e),
        .gpio_i  (gpio_i),
        .sys_wen (sys_wen),
        .sys_wad (sys_wad),
        .sys_wdt (sys_wdt),
        .sys_ren (sys_ren),
        .sys_rad (sys_rad),
        .sys_rdt (sys_rdt),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; the write lands on the rising edge between
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sys_wen = 1'b1;
        sys_wad = a;
        sys_wdt = d;
        @(negedge clk);
        sys_wen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        sys_ren = 1'b1;
        sys_rad = a;
        #1;
        d = sys_rdt;
        sys_ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gpio_i = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        sys_wad = '0; sys_rad = '0; sys_wdt = '0;
        repeat (2) @(negedge clk);
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_e", 32'(gpio_e), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd(4'd0, rdat); check("rst_oe_rd", rdat, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Output data atomics and output enable
        wr(4'd1, 32'h0000_00F0);
        wr(4'd2, 32'h0000_0003);
        wr(4'd3, 32'h0000_0010);
        wr(4'd4, 32'h0000_0101);
        check("od_atomic", 32'(gpio_o), 32'h0000_01E2);
        rd(4'd2, rdat); check("od_set_rd", rdat, 32'h0000_01E2);
        rd(4'd4, rdat); check("od_tgl_rd", rdat, 32'h0000_01E2);
        @(negedge clk);
        wr(4'd0, 32'h0000_00FF);
        check("oe_out", 32'(gpio_e), 32'h0000_00FF);
        wr(4'd0, 32'hFFFF_FFFF);
        rd(4'd0, rdat); check("oe_upper_bits", rdat, 32'h0000_FFFF);
        @(negedge clk);
        wr(4'd14, 32'h0000_0005);
        rd(4'd14, rdat); check("rsv14_rd", rdat, 32'h0);
        rd(4'd15, rdat); check("rsv15_rd", rdat, 32'h0);
        @(negedge clk);

        // Input data path latency through the synchronizer
        wr(4'd5, 32'h1);
        gpio_i[0] = 1'b1;
        @(negedge clk);
        rd(4'd6, rdat); check("id_after_1", rdat, 32'h0);
        @(negedge clk);
        rd(4'd6, rdat); check("id_after_2", rdat, 32'h1);
        @(negedge clk);
        wr(4'd5, 32'h0);
        rd(4'd6, rdat); check("id_ie_off", rdat, 32'h0);
        gpio_i[0] = 1'b0;
        @(negedge clk);

        // Pin 3 rising edge, sticky status, W1C
        wr(4'd8, 32'h8);
        wr(4'd9, 32'h8);
        wr(4'd7, 32'h8);
        gpio_i[3] = 1'b1;
        repeat (2) @(negedge clk);
        rd(4'd11, rdat); check("edge_lat_2", rdat, 32'h0);
        @(negedge clk);
        rd(4'd11, rdat); check("edge_lat_3", rdat, 32'h8);
        check("edge_irq", 32'(irq), 32'h1);
        gpio_i[3] = 1'b0;
        repeat (4) @(negedge clk);
        rd(4'd11, rdat); check("edge_sticky", rdat, 32'h8);
        check("edge_irq_held", 32'(irq), 32'h1);
        @(negedge clk);
        wr(4'd11, 32'h8);
        rd(4'd11, rdat); check("edge_w1c", rdat, 32'h0);
        check("edge_irq_clr", 32'(irq), 32'h0);
        @(negedge clk);

        // Pin 5 both-edges, and set beating a same-cycle clear
        wr(4'd10, 32'h20);
        wr(4'd8, 32'h28);
        wr(4'd7, 32'h28);
        gpio_i[5] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_i[5] = 1'b0;
        repeat (4) @(negedge clk);
        rd(4'd11, rdat); check("bth_set", rdat, 32'h20);
        @(negedge clk);
        wr(4'd11, 32'h20);
        rd(4'd11, rdat); check("bth_w1c", rdat, 32'h0);
        gpio_i[5] = 1'b1;
        repeat (2) @(negedge clk);
        wr(4'd11, 32'h20);
        rd(4'd11, rdat); check("set_wins", rdat, 32'h20);
        check("set_wins_irq", 32'(irq), 32'h1);
        @(negedge clk);

        // Pin 2 active-low level; dropping ENA of pin 5 clears its sticky bit
        wr(4'd7, 32'h4);
        rd(4'd11, rdat); check("lvl_sts", rdat, 32'h4);
        check("lvl_irq", 32'(irq), 32'h1);
        @(negedge clk);
        wr(4'd11, 32'h4);
        rd(4'd11, rdat); check("lvl_w1c_ignored", rdat, 32'h4);
        gpio_i[2] = 1'b1;
        @(negedge clk);
        check("lvl_irq_lat1", 32'(irq), 32'h1);
        @(negedge clk);
        check("lvl_irq_lat2", 32'(irq), 32'h0);
        rd(4'd11, rdat); check("lvl_sts_off", rdat, 32'h0);
        @(negedge clk);
        wr(4'd7, 32'h0);

`ifdef TCB_PERI_GPIO_DEBOUNCE_EN
        // Debounce: prescaler tick every 4 cycles, 4 stable ticks to accept
        wr(4'd5, 32'h1);
        wr(4'd12, 32'h3);
        wr(4'd13, 32'h1);
        rd(4'd12, rdat); check("dbc_pre_rd", rdat, 32'h3);
        repeat (3) @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (10) @(negedge clk);
        gpio_i[0] = 1'b0;
        repeat (20) @(negedge clk);
        rd(4'd6, rdat); check("dbc_glitch", rdat, 32'h0);
        gpio_i[0] = 1'b1;
        repeat (24) @(negedge clk);
        rd(4'd6, rdat); check("dbc_stable", rdat, 32'h1);
        gpio_i[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(4'd5, 32'h1);
        rd(4'd6, rdat); check("dbc_rst_filt", rdat, 32'h0);
        @(negedge clk);
        wr(4'd1, 32'h0000_01E2);
`else
        // Debounce registers absent in this build
        wr(4'd12, 32'h3);
        wr(4'd13, 32'h1);
        rd(4'd12, rdat); check("dbc_pre_absent", rdat, 32'h0);
        rd(4'd13, rdat); check("dbc_ena_absent", rdat, 32'h0);
        @(negedge clk);
`endif

        // Asynchronous reset clears outputs without waiting for a clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_gpio_o", 32'(gpio_o), 32'h0);
        check("async_rst_gpio_e", 32'(gpio_e), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
